// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Covers the channel state encoding, the channel-select width and write-time clamping.
package clkgen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } chan_state_e;

  localparam int unsigned MIN_DIV = 2;

  // Select width for n channels, never narrower than one bit.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // d must already be clamped.
  function automatic int unsigned clamp_high(input int unsigned d, input int unsigned h);
    return (h == 0 || h >= d) ? (d >> 1) : h;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: shadow config, period counter, run/drain/idle FSM and
// registered clock/strobe outputs that are all derived from the same next count.
module clk_div_chan
  import clkgen_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 24,
  parameter bit          RESET_EN    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic [DIV_W-1:0] wr_high_i,
  input  logic             wr_en_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             pend_o
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d, high_q, high_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d, sh_high_q, sh_high_d;
  logic             en_q, en_d, pend_q, pend_d;
  logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic             wrap, run_d;

  assign wrap = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    sh_div_d  = sh_div_q;
    sh_high_d = sh_high_q;
    pend_d    = pend_q;
    // A write's enable takes effect on the accepting edge.
    en_d      = wr_i ? wr_en_i : en_q;

    unique case (state_q)
      StRun, StDrain: begin
        if (sync_i || wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            div_d  = sh_div_q;
            high_d = sh_high_q;
            pend_d = 1'b0;
          end
          if (en_d)        state_d = StRun;
          else if (sync_i) state_d = StDrain;
          else             state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + DIV_W'(1);
          state_d = en_d ? StRun : StDrain;
        end
        if (wr_i) begin
          if (sync_i) begin
            div_d  = wr_div_i;
            high_d = wr_high_i;
            pend_d = 1'b0;
          end else begin
            sh_div_d  = wr_div_i;
            sh_high_d = wr_high_i;
            pend_d    = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = sh_div_q;
          high_d = sh_high_q;
          pend_d = 1'b0;
        end
        if (wr_i) begin
          div_d  = wr_div_i;
          high_d = wr_high_i;
          pend_d = 1'b0;
        end
        state_d = en_d ? StRun : StIdle;
      end
    endcase

    run_d  = (state_d != StIdle);
    clk_d  = run_d && (cnt_d < high_d);
    rise_d = run_d && (cnt_d == '0);
    fall_d = run_d && (cnt_d == high_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      high_q    <= DIV_W'(DEFAULT_DIV >> 1);
      sh_div_q  <= DIV_W'(DEFAULT_DIV);
      sh_high_q <= DIV_W'(DEFAULT_DIV >> 1);
      en_q      <= RESET_EN;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sh_div_q  <= sh_div_d;
      sh_high_q <= sh_high_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH programmable clock dividers off one reference clock: config decode and clamping,
// error pulse, ready and sync fan-out live here; per-channel timing lives in clk_div_chan.
module multi_clk_div
  import clkgen_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 4,
  parameter int unsigned  DIV_W       = 16,
  parameter int unsigned  DEFAULT_DIV = 24,
  parameter bit           RESET_EN    = 1'b1,
  localparam int unsigned CH_W        = clogb2(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] fall_stb,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic             ready_q, err_q;
  logic             accept;
  logic [DIV_W-1:0] cl_div, cl_high;
  logic             cl_err;

  assign accept  = cfg_valid && ready_q;
  assign cl_div  = DIV_W'(clamp_div(32'(cfg_div)));
  assign cl_high = DIV_W'(clamp_high(32'(cl_div), 32'(cfg_high)));
  assign cl_err  = (cl_div != cfg_div) || (cl_high != cfg_high);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= accept && cl_err;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV),
      .RESET_EN   (RESET_EN)
    ) u_chan (
      .clk_i    (refclk),
      .rst_ni   (rst_n),
      .wr_i     (accept && (cfg_ch == CH_W'(g))),
      .wr_div_i (cl_div),
      .wr_high_i(cl_high),
      .wr_en_i  (cfg_en),
      .sync_i   (sync_i),
      .clk_o    (clk_o[g]),
      .rise_o   (rise_stb[g]),
      .fall_o   (fall_stb[g]),
      .pend_o   (cfg_pending[g])
    );
  end

endmodule
